// File: rtl/dut_vector_seq.sv
// ============================================================================
// dut_vector_seq : vector FIFO, timing-set sequencer, pin drive and strobe compare
// Rev 1.0
// ============================================================================
`default_nettype none

module dut_vector_seq #(
    parameter int PINS  = 128,
    parameter int DEPTH = 16,
    parameter int TSETS = 4,
    parameter int TW    = 8,
    localparam int TSW  = (TSETS > 1) ? $clog2(TSETS) : 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            i_vec_valid,
    output logic            o_vec_ready,
    input  logic [PINS-1:0] i_vec_drive,
    input  logic [PINS-1:0] i_vec_en,
    input  logic [PINS-1:0] i_vec_expect,
    input  logic [PINS-1:0] i_vec_mask,
    input  logic [TSW-1:0]  i_vec_tset,
    input  logic [PINS-1:0] i_pin_rz,
    input  logic            i_cfg_we,
    input  logic [TSW-1:0]  i_cfg_sel,
    input  logic [TW-1:0]   i_cfg_lead,
    input  logic [TW-1:0]   i_cfg_trail,
    input  logic [TW-1:0]   i_cfg_strobe,
    input  logic [TW-1:0]   i_cfg_length,
    input  logic            i_start,
    input  logic            i_abort,
    input  logic [PINS-1:0] i_pin_in,
    output logic [PINS-1:0] o_pin_out,
    output logic [PINS-1:0] o_pin_oe,
    output logic            o_busy,
    output logic            o_done,
    output logic            o_fail,
    output logic [PINS-1:0] o_fail_pins,
    output logic [15:0]     o_fail_count,
    output logic [15:0]     o_vec_count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]   c_ptr_one = {{AW{1'b0}}, 1'b1};
    localparam logic [TW-1:0] c_tw_one  = {{(TW-1){1'b0}}, 1'b1};

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FETCH = 2'd1;
    localparam logic [1:0] S_RUN   = 2'd2;

    logic [1:0]      r_state, w_state_nxt;
    logic [AW:0]     r_wptr, r_rptr;
    logic            w_empty, w_full, w_push, w_pop;
    logic            w_busy, w_run, w_finish, w_clear, w_done_empty;

    logic [PINS-1:0] r_mem_drive  [DEPTH];
    logic [PINS-1:0] r_mem_en     [DEPTH];
    logic [PINS-1:0] r_mem_expect [DEPTH];
    logic [PINS-1:0] r_mem_mask   [DEPTH];
    logic [TSW-1:0]  r_mem_tset   [DEPTH];

    logic [TW-1:0]   r_lead [TSETS];
    logic [TW-1:0]   r_trail[TSETS];
    logic [TW-1:0]   r_strobe[TSETS];
    logic [TW-1:0]   r_length[TSETS];

    logic [PINS-1:0] r_act_drive, r_act_en, r_act_expect, r_act_mask;
    logic [TSW-1:0]  r_act_tset;
    logic [TW-1:0]   r_tick;

    logic [PINS-1:0] r_pin_out, r_pin_oe, r_fail_pins;
    logic            r_done, r_fail;
    logic [15:0]     r_fail_count, r_vec_count;

    logic [TW-1:0]   w_lead, w_trail, w_strobe, w_len, w_len_m1;
    logic            w_last, w_in_pulse, w_at_lead, w_strobe_hit;
    logic [PINS-1:0] w_pin_nxt, w_miss;

    // Wrap bit distinguishes full from empty when the indices coincide
    assign w_empty     = (r_wptr == r_rptr);
    assign w_full      = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
    assign o_vec_ready = !w_full;
    assign w_push      = i_vec_valid && !w_full && !i_abort;

    assign w_lead   = r_lead[r_act_tset];
    assign w_trail  = r_trail[r_act_tset];
    assign w_strobe = r_strobe[r_act_tset];
    assign w_len    = r_length[r_act_tset];
    assign w_len_m1 = (w_len == '0) ? '0 : (w_len - c_tw_one);
    assign w_last   = (r_tick == w_len_m1);

    assign w_in_pulse   = (r_tick >= w_lead) && (r_tick < w_trail);
    assign w_at_lead    = (r_tick == w_lead);
    assign w_strobe_hit = (r_tick == w_strobe);
    assign w_pin_nxt    = (i_pin_rz & r_act_drive & {PINS{w_in_pulse}})
                        | (~i_pin_rz & (w_at_lead ? r_act_drive : r_pin_out));
    assign w_miss       = (i_pin_in ^ r_act_expect) & r_act_mask & ~r_act_en;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (i_abort) begin
            w_state_nxt = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:  if (i_start && !w_empty) w_state_nxt = S_FETCH;
                S_FETCH: w_state_nxt = S_RUN;
                S_RUN:   if (w_last && w_empty) w_state_nxt = S_IDLE;
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    always_comb begin
        w_busy       = (r_state != S_IDLE);
        w_pop        = 1'b0;
        w_run        = 1'b0;
        w_finish     = 1'b0;
        w_clear      = 1'b0;
        w_done_empty = 1'b0;
        if (!i_abort) begin
            case (r_state)
                S_IDLE: begin
                    w_clear      = i_start && !w_empty;
                    w_done_empty = i_start && w_empty;
                end
                S_FETCH: w_pop = 1'b1;
                S_RUN: begin
                    w_run    = 1'b1;
                    w_pop    = w_last && !w_empty;
                    w_finish = w_last && w_empty;
                end
                default: w_pop = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + c_ptr_one;
            if (i_abort)    r_rptr <= r_wptr;
            else if (w_pop) r_rptr <= r_rptr + c_ptr_one;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_drive [r_wptr[AW-1:0]] <= i_vec_drive;
            r_mem_en    [r_wptr[AW-1:0]] <= i_vec_en;
            r_mem_expect[r_wptr[AW-1:0]] <= i_vec_expect;
            r_mem_mask  [r_wptr[AW-1:0]] <= i_vec_mask;
            r_mem_tset  [r_wptr[AW-1:0]] <= i_vec_tset;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < TSETS; i++) begin
                r_lead[i]   <= '0;
                r_trail[i]  <= '0;
                r_strobe[i] <= '0;
                r_length[i] <= '0;
            end
        end else if (i_cfg_we && !w_busy) begin
            r_lead[i_cfg_sel]   <= i_cfg_lead;
            r_trail[i_cfg_sel]  <= i_cfg_trail;
            r_strobe[i_cfg_sel] <= i_cfg_strobe;
            r_length[i_cfg_sel] <= i_cfg_length;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_act_drive  <= '0;
            r_act_en     <= '0;
            r_act_expect <= '0;
            r_act_mask   <= '0;
            r_act_tset   <= '0;
            r_tick       <= '0;
        end else if (w_pop) begin
            r_act_drive  <= r_mem_drive [r_rptr[AW-1:0]];
            r_act_en     <= r_mem_en    [r_rptr[AW-1:0]];
            r_act_expect <= r_mem_expect[r_rptr[AW-1:0]];
            r_act_mask   <= r_mem_mask  [r_rptr[AW-1:0]];
            r_act_tset   <= r_mem_tset  [r_rptr[AW-1:0]];
            r_tick       <= '0;
        end else if (w_finish) begin
            r_tick <= '0;
        end else if (w_run) begin
            r_tick <= r_tick + c_tw_one;
        end
    end

    // Abort suppresses the strobe and count update of its own cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pin_out    <= '0;
            r_pin_oe     <= '0;
            r_done       <= 1'b0;
            r_fail       <= 1'b0;
            r_fail_pins  <= '0;
            r_fail_count <= '0;
            r_vec_count  <= '0;
        end else begin
            r_done <= w_finish || w_done_empty;
            if (i_abort) begin
                r_pin_oe <= '0;
            end else if (w_run) begin
                r_pin_oe  <= w_finish ? '0 : r_act_en;
                r_pin_out <= w_pin_nxt;
                if (w_strobe_hit) begin
                    r_fail_pins <= r_fail_pins | w_miss;
                    if (|w_miss) begin
                        r_fail <= 1'b1;
                        if (r_fail_count != 16'hFFFF) r_fail_count <= r_fail_count + 16'd1;
                    end
                end
                if (w_last) r_vec_count <= r_vec_count + 16'd1;
            end else if (w_clear) begin
                r_fail       <= 1'b0;
                r_fail_pins  <= '0;
                r_fail_count <= '0;
                r_vec_count  <= '0;
            end
        end
    end

    assign o_pin_out    = r_pin_out;
    assign o_pin_oe     = r_pin_oe;
    assign o_busy       = w_busy;
    assign o_done       = r_done;
    assign o_fail       = r_fail;
    assign o_fail_pins  = r_fail_pins;
    assign o_fail_count = r_fail_count;
    assign o_vec_count  = r_vec_count;

endmodule

`default_nettype wire

// File: tb/tb_dut_vector_seq.sv
// ============================================================================
// tb_dut_vector_seq : directed vectors with hand-computed expectations
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_dut_vector_seq;

    localparam int PINS = 8;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            vec_valid = 1'b0, vec_ready;
    logic [PINS-1:0] vec_drive = '0, vec_en = '0, vec_expect = '0, vec_mask = '0;
    logic [1:0]      vec_tset = '0;
    logic [PINS-1:0] pin_rz = 8'h0F;
    logic            cfg_we = 1'b0;
    logic [1:0]      cfg_sel = '0;
    logic [7:0]      cfg_lead = '0, cfg_trail = '0, cfg_strobe = '0, cfg_length = '0;
    logic            start = 1'b0, abort = 1'b0;
    logic [PINS-1:0] pin_in = '0;
    logic [PINS-1:0] pin_out, pin_oe, fail_pins;
    logic            busy, done, fail;
    logic [15:0]     fail_count, vec_count;

    int n_vec  = 0;
    int n_miss = 0;

    dut_vector_seq #(.PINS(PINS), .DEPTH(16), .TSETS(4), .TW(8)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .i_vec_valid(vec_valid), .o_vec_ready(vec_ready),
        .i_vec_drive(vec_drive), .i_vec_en(vec_en), .i_vec_expect(vec_expect),
        .i_vec_mask(vec_mask), .i_vec_tset(vec_tset), .i_pin_rz(pin_rz),
        .i_cfg_we(cfg_we), .i_cfg_sel(cfg_sel), .i_cfg_lead(cfg_lead),
        .i_cfg_trail(cfg_trail), .i_cfg_strobe(cfg_strobe), .i_cfg_length(cfg_length),
        .i_start(start), .i_abort(abort), .i_pin_in(pin_in),
        .o_pin_out(pin_out), .o_pin_oe(pin_oe), .o_busy(busy), .o_done(done),
        .o_fail(fail), .o_fail_pins(fail_pins), .o_fail_count(fail_count),
        .o_vec_count(vec_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic cfg(input logic [1:0] sel, input logic [7:0] lead, input logic [7:0] trail,
                       input logic [7:0] strobe, input logic [7:0] len);
        cfg_we = 1'b1; cfg_sel = sel; cfg_lead = lead; cfg_trail = trail;
        cfg_strobe = strobe; cfg_length = len;
        step();
        cfg_we = 1'b0;
    endtask

    task automatic push(input logic [7:0] drv, input logic [7:0] en, input logic [7:0] exp,
                        input logic [7:0] msk, input logic [1:0] ts);
        vec_valid = 1'b1; vec_drive = drv; vec_en = en; vec_expect = exp;
        vec_mask = msk; vec_tset = ts;
        step();
        vec_valid = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic run_to_idle(output int bc, output int dn);
        bc = 0;
        dn = 0;
        for (int i = 0; i < 400 && busy; i++) begin
            bc++;
            step();
            if (done) dn++;
        end
        chk("idle_wait", {31'd0, busy}, 32'd0);
    endtask

    logic [7:0] exp_out [9];
    logic [7:0] exp_oe  [9];
    logic [4:0] pat;
    int bc, dn;

    initial begin
        exp_out = '{8'h00, 8'h00, 8'h00, 8'hFF, 8'hFF, 8'hFF, 8'hF0, 8'hF0, 8'hF0};
        exp_oe  = '{8'h00, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h00};

        #1;
        chk("rst_ready", {31'd0, vec_ready}, 32'd1);
        chk("rst_busy",  {31'd0, busy}, 32'd0);
        chk("rst_oe",    {24'd0, pin_oe}, 32'd0);
        chk("rst_vcnt",  {16'd0, vec_count}, 32'd0);
        step(2);
        rst_n = 1'b1;
        step();

        // Single vector, set 0: lead 2, trail 5, length 8
        cfg(2'd0, 8'd2, 8'd5, 8'd9, 8'd8);
        push(8'hFF, 8'hFF, 8'h00, 8'h00, 2'd0);
        pulse_start();
        chk("t2_busy", {31'd0, busy}, 32'd1);
        for (int k = 0; k < 9; k++) begin
            step();
            chk($sformatf("t2_out%0d", k), {24'd0, pin_out}, {24'd0, exp_out[k]});
            chk($sformatf("t2_oe%0d", k),  {24'd0, pin_oe},  {24'd0, exp_oe[k]});
            chk($sformatf("t2_done%0d", k), {31'd0, done}, (k == 8) ? 32'd1 : 32'd0);
        end
        chk("t2_busy_end", {31'd0, busy}, 32'd0);
        step();
        chk("t2_done_off", {31'd0, done}, 32'd0);
        chk("t2_vcnt", {16'd0, vec_count}, 32'd1);

        // Sixteen vectors back-to-back, alternating length 8 / 4
        cfg(2'd1, 8'd0, 8'd2, 8'd9, 8'd4);
        for (int i = 0; i < 16; i++) push(8'h55, 8'hFF, 8'h00, 8'h00, 2'(i % 2));
        chk("t3_full", {31'd0, vec_ready}, 32'd0);
        push(8'hAA, 8'hFF, 8'h00, 8'h00, 2'd0);
        chk("t3_full2", {31'd0, vec_ready}, 32'd0);
        pulse_start();
        run_to_idle(bc, dn);
        chk("t3_cycles", bc, 32'd97);
        chk("t3_dones", dn, 32'd1);
        chk("t3_vcnt", {16'd0, vec_count}, 32'd16);
        chk("t3_nofail", {31'd0, fail}, 32'd0);
        chk("t3_empty", {31'd0, vec_ready}, 32'd1);

        // Strobe compare: bit0 mismatches on vectors 0, 2, 4; bit1 mismatch is masked
        cfg(2'd2, 8'd0, 8'd0, 8'd3, 8'd5);
        for (int i = 0; i < 5; i++) push(8'h00, 8'h00, 8'h00, 8'h01, 2'd2);
        pat = 5'b10101;
        pulse_start();
        for (int v = 0; v < 5; v++) begin
            pin_in = {6'd0, 1'b1, pat[v]};
            step(5);
        end
        run_to_idle(bc, dn);
        chk("t4_dones", dn, 32'd1);
        chk("t4_fail", {31'd0, fail}, 32'd1);
        chk("t4_pins", {24'd0, fail_pins}, 32'h01);
        chk("t4_fcnt", {16'd0, fail_count}, 32'd3);
        chk("t4_vcnt", {16'd0, vec_count}, 32'd5);

        // Abort during the fourth of ten vectors, with START and a write alongside
        cfg(2'd3, 8'd0, 8'd0, 8'd1, 8'd4);
        pin_in = 8'h01;
        for (int i = 0; i < 10; i++) push(8'h80, 8'h80, 8'h00, 8'h01, 2'd3);
        pulse_start();
        chk("t5_clear", {31'd0, fail}, 32'd0);
        step(14);
        chk("t5_oe_run", {24'd0, pin_oe}, 32'h80);
        abort = 1'b1; start = 1'b1; vec_valid = 1'b1;
        step();
        abort = 1'b0; start = 1'b0; vec_valid = 1'b0;
        chk("t5_busy", {31'd0, busy}, 32'd0);
        chk("t5_oe", {24'd0, pin_oe}, 32'd0);
        chk("t5_done", {31'd0, done}, 32'd0);
        chk("t5_vcnt", {16'd0, vec_count}, 32'd3);
        chk("t5_fcnt", {16'd0, fail_count}, 32'd3);
        dn = 0;
        for (int i = 0; i < 4; i++) begin
            step();
            if (done) dn++;
        end
        chk("t5_nodone", dn, 32'd0);
        pulse_start();
        chk("t5_empty_done", {31'd0, done}, 32'd1);
        chk("t5_empty_busy", {31'd0, busy}, 32'd0);
        chk("t5_fail_kept", {31'd0, fail}, 32'd1);
        pin_in = 8'h00;

        // Zero length gives one-tick cycles; config writes while busy are dropped
        cfg(2'd1, 8'd0, 8'd1, 8'd9, 8'd0);
        for (int i = 0; i < 3; i++) push(8'h01, 8'h00, 8'h00, 8'h00, 2'd1);
        pulse_start();
        cfg_we = 1'b1; cfg_sel = 2'd0; cfg_length = 8'd2;
        cfg_lead = 8'd0; cfg_trail = 8'd0; cfg_strobe = 8'd0;
        run_to_idle(bc, dn);
        cfg_we = 1'b0;
        chk("t6_cycles", bc, 32'd4);
        chk("t6_dones", dn, 32'd1);
        chk("t6_vcnt", {16'd0, vec_count}, 32'd3);
        push(8'h00, 8'h00, 8'h00, 8'h00, 2'd0);
        pulse_start();
        run_to_idle(bc, dn);
        chk("t6_set0_kept", bc, 32'd9);

        // Reset mid-run
        push(8'hFF, 8'hFF, 8'h00, 8'h00, 2'd0);
        push(8'hFF, 8'hFF, 8'h00, 8'h00, 2'd0);
        pulse_start();
        step(5);
        chk("t7_oe_run", {24'd0, pin_oe}, 32'hFF);
        rst_n = 1'b0;
        #1;
        chk("t7_oe", {24'd0, pin_oe}, 32'd0);
        chk("t7_out", {24'd0, pin_out}, 32'd0);
        chk("t7_busy", {31'd0, busy}, 32'd0);
        chk("t7_ready", {31'd0, vec_ready}, 32'd1);
        chk("t7_vcnt", {16'd0, vec_count}, 32'd0);
        step();
        rst_n = 1'b1;
        step();
        pulse_start();
        chk("t7_empty_done", {31'd0, done}, 32'd1);
        push(8'h00, 8'h00, 8'h00, 8'h00, 2'd0);
        pulse_start();
        run_to_idle(bc, dn);
        chk("t7_tset_cleared", bc, 32'd2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

`default_nettype wire
